// File: rtl/plant_pkg.sv
// +----------------------------------------------------------------------+
// | plant_pkg                                                            |
// | Q8.8 widths and saturation helpers for the plant emulator datapath.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package plant_pkg;

   localparam int Y_W    = 16;
   localparam int DIFF_W = 17;

   // Clamp a signed 10-bit command sum to the unsigned 8-bit range.
   function automatic logic [7:0] sat8(input logic signed [9:0] s);
      if (s < 10'sd0)
         return 8'h00;
      else if (s > 10'sd255)
         return 8'hFF;
      else
         return s[7:0];
   endfunction

   // Keep the Q8.8 state inside 0.0 .. 255.0.
   function automatic logic [Y_W-1:0] sat_y(input logic signed [Y_W+1:0] v);
      if (v < 18'sd0)
         return 16'h0000;
      else if (v > 18'sh0FF00)
         return 16'hFF00;
      else
         return v[Y_W-1:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/plant_emulator_if.sv
// +----------------------------------------------------------------------+
// | plant_emulator_if                                                    |
// | Command/feedback bundle between controller and plant emulator.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface plant_emulator_if;

   logic [7:0] control_signal;
   logic [7:0] disturbance;
   logic       enable;
   logic [7:0] feedback;
   logic       sample_valid;
   logic       pwm_out;
   logic       settled;

   modport master (
      output control_signal, disturbance, enable,
      input  feedback, sample_valid, pwm_out, settled
   );

   modport slave (
      input  control_signal, disturbance, enable,
      output feedback, sample_valid, pwm_out, settled
   );

endinterface

`default_nettype wire

// File: rtl/plant_emulator_pwm_gen.sv
// +----------------------------------------------------------------------+
// | pwm_gen                                                              |
// | 256-cycle PWM; duty is latched at period end so changes never split. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pwm_gen (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] duty_in,
   output logic       pwm_out
);

   logic [7:0] r_pcnt;
   logic [7:0] r_duty;
   logic       r_pwm;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pcnt <= 8'h00;
         r_duty <= 8'h00;
         r_pwm  <= 1'b0;
      end else begin
         r_pcnt <= r_pcnt + 8'h01;
         r_pwm  <= (r_pcnt < r_duty);
         if (r_pcnt == 8'hFF)
            r_duty <= duty_in;
      end
   end

   assign pwm_out = r_pwm;

endmodule

`default_nettype wire

// File: rtl/plant_emulator.sv
// +----------------------------------------------------------------------+
// | plant_emulator                                                       |
// | First-order lag plant with disturbance, prescaled update and PWM.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module plant_emulator
   import plant_pkg::*;
#(
   parameter int         DIV      = 16,
   parameter int         SHIFT    = 3,
   parameter logic [7:0] FB_INIT  = 8'h00,
   parameter int         SETTLE_N = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   plant_emulator_if.slave  bus
);

   localparam int              c_PW          = $clog2(DIV);
   localparam int              c_CW          = $clog2(SETTLE_N + 1);
   localparam logic [c_PW-1:0] c_PRESC_MAX   = c_PW'(DIV - 1);
   localparam logic [c_CW-1:0] c_SETTLE_MAX  = c_CW'(SETTLE_N);

   logic [c_PW-1:0]          r_presc;
   logic [Y_W-1:0]           r_y;
   logic [c_CW-1:0]          r_cnt;
   logic                     r_sv;

   logic                     w_tick;
   logic signed [9:0]        w_sum;
   logic [7:0]               w_target;
   logic signed [DIFF_W-1:0] w_diff;
   logic signed [DIFF_W-1:0] w_shift;
   logic signed [DIFF_W-1:0] w_delta;
   logic [Y_W-1:0]           w_y_next;
   logic signed [9:0]        w_err;
   logic                     w_in_band;

   assign w_tick = bus.enable && (r_presc == c_PRESC_MAX);

   always_comb begin
      w_sum    = $signed({2'b00, bus.control_signal})
               + $signed({{2{bus.disturbance[7]}}, bus.disturbance});
      w_target = sat8(w_sum);
      w_diff   = $signed({1'b0, w_target, 8'h00}) - $signed({1'b0, r_y});
      w_shift  = w_diff >>> SHIFT;
      // A nonzero error always moves y by at least one LSB so it lands exactly.
      if ((w_shift == '0) && (w_diff != '0))
         w_delta = w_diff[DIFF_W-1] ? '1 : DIFF_W'(1);
      else
         w_delta = w_shift;
      w_y_next  = sat_y({2'b00, r_y} + {w_delta[DIFF_W-1], w_delta});
      w_err     = $signed({2'b00, w_target}) - $signed({2'b00, w_y_next[Y_W-1:8]});
      w_in_band = (w_err <= 10'sd1) && (w_err >= -10'sd1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_y     <= {FB_INIT, 8'h00};
         r_cnt   <= '0;
         r_sv    <= 1'b0;
      end else begin
         r_sv <= w_tick;
         if (w_tick) begin
            r_presc <= '0;
            r_y     <= w_y_next;
            if (!w_in_band)
               r_cnt <= '0;
            else if (r_cnt != c_SETTLE_MAX)
               r_cnt <= r_cnt + c_CW'(1);
         end else if (bus.enable) begin
            r_presc <= r_presc + c_PW'(1);
         end
      end
   end

   assign bus.feedback     = r_y[Y_W-1:8];
   assign bus.sample_valid = r_sv;
   assign bus.settled      = (r_cnt == c_SETTLE_MAX);

   pwm_gen u_pwm_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .duty_in (bus.control_signal),
      .pwm_out (bus.pwm_out)
   );

endmodule

`default_nettype wire

// File: tb/tb_plant_emulator.sv
// +----------------------------------------------------------------------+
// | tb_plant_emulator                                                    |
// | Randomised and directed checks against a cycle-level plant model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_plant_emulator;

   localparam int P_DIV      = 4;
   localparam int P_SHIFT    = 1;
   localparam int P_FB_INIT  = 0;
   localparam int P_SETTLE_N = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] u, d;
   logic       en;

   int n_total = 0;
   int n_bad   = 0;

   // reference state, plain integers
   int m_y, m_presc, m_cnt, m_pcnt, m_duty;
   int m_sv, m_pwm;

   plant_emulator_if bus ();
   assign bus.control_signal = u;
   assign bus.disturbance    = d;
   assign bus.enable         = en;

   plant_emulator #(
      .DIV      (P_DIV),
      .SHIFT    (P_SHIFT),
      .FB_INIT  (8'(P_FB_INIT)),
      .SETTLE_N (P_SETTLE_N)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   // floor(a / 2^s) for signed a
   function automatic int floor_div(input int a, input int s);
      int p;
      p = 1 << s;
      if (a >= 0) return a / p;
      return -((-a + p - 1) / p);
   endfunction

   task automatic step_clk();
      int cu, cd, cen, crst, tgt, diff, dl;
      cu = u; cd = $signed(d); cen = en; crst = rst_n;
      @(posedge clk);
      if (!crst) begin
         m_y = P_FB_INIT * 256; m_presc = 0; m_cnt = 0; m_sv = 0;
         m_pcnt = 0; m_duty = 0; m_pwm = 0;
      end else begin
         m_sv = (cen && m_presc == P_DIV - 1) ? 1 : 0;
         if (m_sv == 1) begin
            tgt  = clampi(cu + cd, 0, 255);
            diff = tgt * 256 - m_y;
            dl   = floor_div(diff, P_SHIFT);
            if (dl == 0 && diff != 0) dl = (diff > 0) ? 1 : -1;
            m_y  = clampi(m_y + dl, 0, 16'hFF00);
            if (tgt - m_y / 256 <= 1 && m_y / 256 - tgt <= 1)
               m_cnt = (m_cnt < P_SETTLE_N) ? m_cnt + 1 : P_SETTLE_N;
            else
               m_cnt = 0;
            m_presc = 0;
         end else if (cen) begin
            m_presc++;
         end
         m_pwm = (m_pcnt < m_duty) ? 1 : 0;
         if (m_pcnt == 255) m_duty = cu;
         m_pcnt = (m_pcnt + 1) % 256;
      end
      #1;
      chk("feedback", bus.feedback, m_y / 256);
      chk("sample_valid", bus.sample_valid, m_sv);
      chk("settled", bus.settled, (m_cnt == P_SETTLE_N) ? 1 : 0);
      chk("pwm_out", bus.pwm_out, m_pwm);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step_clk();
   endtask

   task automatic wait_pulse(input string tag);
      int k;
      k = 0;
      do begin
         step_clk();
         k++;
      end while (!bus.sample_valid && k < 4 * P_DIV);
      chk({tag, "_pulse"}, bus.sample_valid, 1);
   endtask

   task automatic pwm_window(input string tag, input int duty);
      int hi;
      u = 8'(duty);
      run(300);
      while (m_pcnt != 0) step_clk();
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         step_clk();
         hi += bus.pwm_out;
      end
      chk(tag, hi, duty);
   endtask

   initial begin
      int exp_step[7] = '{64, 96, 112, 120, 124, 126, 127};
      int fb0, svc, hi, k;

      rst_n = 1'b0; u = 8'd128; d = 8'd0; en = 1'b1;
      run(2);
      chk("reset_feedback", bus.feedback, P_FB_INIT);
      chk("reset_sv", bus.sample_valid, 0);
      chk("reset_settled", bus.settled, 0);

      // step response
      rst_n = 1'b1;
      k = 0;
      do begin step_clk(); k++; end while (!bus.sample_valid && k < 4 * P_DIV);
      chk("first_pulse_latency", k, P_DIV);
      chk("step_0", bus.feedback, exp_step[0]);
      for (int i = 1; i < 7; i++) begin
         wait_pulse("step");
         chk($sformatf("step_%0d", i), bus.feedback, exp_step[i]);
      end
      wait_pulse("step");
      wait_pulse("step");
      chk("settled_before", bus.settled, 0);
      wait_pulse("step");
      chk("settled_rise", bus.settled, 1);
      for (int i = 0; i < 8; i++) wait_pulse("step");
      chk("step_final", bus.feedback, 128);

      // saturation both ways
      u = 8'd250; d = 8'd20;
      for (int i = 0; i < 60; i++) wait_pulse("sat_hi");
      chk("sat_hi_final", bus.feedback, 255);
      u = 8'd10; d = 8'hCE;
      for (int i = 0; i < 60; i++) wait_pulse("sat_lo");
      chk("sat_lo_final", bus.feedback, 0);

      // enable freeze mid-step
      u = 8'd128; d = 8'd0;
      for (int i = 0; i < 3; i++) wait_pulse("frz");
      run(2);
      fb0 = bus.feedback; en = 1'b0; svc = 0;
      for (int i = 0; i < 10; i++) begin
         step_clk();
         svc += bus.sample_valid;
         chk("freeze_hold", bus.feedback, fb0);
      end
      chk("freeze_no_pulse", svc, 0);
      en = 1'b1;

      // drop enable exactly on the tick cycle
      k = 0;
      while (m_presc != P_DIV - 1 && k < 4 * P_DIV) begin step_clk(); k++; end
      en = 1'b0;
      step_clk();
      chk("tick_drop_none", bus.sample_valid, 0);
      run(3);
      en = 1'b1;
      step_clk();
      chk("tick_resume", bus.sample_valid, 1);

      // randomised traffic
      for (int i = 0; i < 2000; i++) begin
         u     = 8'($urandom_range(0, 255));
         d     = 8'($urandom_range(0, 255));
         en    = ($urandom_range(0, 9) < 8);
         rst_n = ($urandom_range(0, 199) != 0);
         if (i % 40 != 0) begin u = bus.control_signal; d = bus.disturbance; end
         step_clk();
      end
      rst_n = 1'b1; en = 1'b1;

      // PWM duties
      d = 8'd0;
      pwm_window("pwm_duty0", 0);
      pwm_window("pwm_duty64", 64);
      pwm_window("pwm_duty255", 255);

      // duty change mid-period
      u = 8'd64;
      run(300);
      while (m_pcnt != 0) step_clk();
      hi = 0;
      for (int i = 1; i <= 256; i++) begin
         step_clk();
         hi += bus.pwm_out;
         if (i == 100) u = 8'd192;
      end
      chk("pwm_change_cur", hi, 64);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         step_clk();
         hi += bus.pwm_out;
      end
      chk("pwm_change_next", hi, 192);

      // reset in the middle of a run
      u = 8'd0;
      for (int i = 0; i < 20; i++) wait_pulse("drain");
      u = 8'd200;
      k = 0;
      while (bus.feedback < 100 && k < 40) begin wait_pulse("rst_ramp"); k++; end
      rst_n = 1'b0;
      step_clk();
      chk("midrst_feedback", bus.feedback, P_FB_INIT);
      chk("midrst_sv", bus.sample_valid, 0);
      chk("midrst_pwm", bus.pwm_out, 0);
      chk("midrst_settled", bus.settled, 0);
      rst_n = 1'b1;
      k = 0;
      do begin step_clk(); k++; end while (!bus.sample_valid && k < 4 * P_DIV);
      chk("midrst_pulse_latency", k, P_DIV);

      // proportional closed loop, Kp=2, setpoint 100
      for (int i = 0; i < 400; i++) begin
         u = 8'(clampi(2 * (100 - int'(bus.feedback)), 0, 255));
         step_clk();
      end
      chk("closed_loop_range", (bus.feedback <= 8'd200) ? 1 : 0, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
